// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: receives 16-bit words one bit per clock,
// MSB-first or LSB-first as chosen at frame start, with abort support.
module shift_deser (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_dir,
  input  logic        i_sdata,
  input  logic        i_abort,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] sr_shift;
  logic        start_ok;
  logic        last_bit;

  assign start_ok = i_start && !i_abort;
  assign last_bit = (cnt_q == 4'd15);
  assign sr_shift = dir_q ? {i_sdata, sr_q[15:1]} : {sr_q[14:0], i_sdata};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SHIFT;
      SHIFT:   if (i_abort || last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        sr_d  = 16'h0000;
        cnt_d = 4'd0;
        dir_d = i_dir;
      end
    end else if (!i_abort) begin
      // The completed word includes the sample taken on this same edge.
      sr_d  = sr_shift;
      cnt_d = cnt_q + 4'd1;
      if (last_bit) begin
        data_d  = sr_shift;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    o_busy  = (state_q == SHIFT);
    o_data  = data_q;
    o_valid = valid_q;
  end

endmodule
